// File: rtl/timer_pkg.sv
// Shared constants for the timer block: TCR bit positions, clock-select encoding, register map.
package timer_pkg;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  localparam int PSC_W = 4;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  // Prescaler bits [cks:0] that must all be ones for a tick.
  function automatic logic [PSC_W-1:0] cks_mask(input cks_e c);
    logic [PSC_W:0] w_full;
    w_full = (5'd2 << c) - 5'd1;
    return w_full[PSC_W-1:0];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler and tick generator. Define TIMER_EXT_CLK_EN to let cks=11 count
// synchronised rising edges of ext_clk instead of pclk/16.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  input  logic i_en,
  input  logic i_clr,
  input  cks_e i_cks,
`ifdef TIMER_EXT_CLK_EN
  input  logic i_ext_clk,
`endif
  output logic o_tick
);

  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] w_mask;
  logic             w_psc_tick;

  // Held at zero while disabled so re-enable always starts a full period.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)             r_psc <= '0;
    else if (i_clr || !i_en)  r_psc <= '0;
    else                      r_psc <= r_psc + 1'b1;
  end

  assign w_mask     = cks_mask(i_cks);
  assign w_psc_tick = i_en && ((r_psc & w_mask) == w_mask);

`ifdef TIMER_EXT_CLK_EN
  logic [2:0] r_ext_sync;
  logic       w_ext_rise;

  // Two flops for metastability, a third to find the rising edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_ext_sync <= '0;
    else          r_ext_sync <= {r_ext_sync[1:0], i_ext_clk};
  end

  assign w_ext_rise = r_ext_sync[1] & ~r_ext_sync[2];
  assign o_tick     = (i_cks == CKS_DIV16) ? (i_en & w_ext_rise) : w_psc_tick;
`else
  assign o_tick     = w_psc_tick;
`endif

endmodule

// File: rtl/timer_counter.sv
// Up/down timer counter with edge-triggered reload and one-cycle overflow/underflow flags.
// Build with TIMER_EXT_CLK_EN to add the ext_clk input used by cks=11.
module timer_counter
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [DATA_WIDTH-1:0] tdr_reg,
  input  logic [DATA_WIDTH-1:0] tcr_reg,
`ifdef TIMER_EXT_CLK_EN
  input  logic                  ext_clk,
`endif
  output logic                  s_ovf,
  output logic                  s_udf,
  output logic [DATA_WIDTH-1:0] tcnt
);

  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  logic [DATA_WIDTH-1:0] r_tcnt;
  logic                  r_load_q;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_load_edge;
  logic                  w_tick;
  logic                  w_dir;
  logic                  w_en;
  cks_e                  w_cks;
  logic                  w_unused_tcr;

  assign w_load_edge  = tcr_reg[TCR_LOAD] & ~r_load_q;
  assign w_dir        = tcr_reg[TCR_DIR];
  assign w_en         = tcr_reg[TCR_EN];
  assign w_cks        = cks_e'(tcr_reg[TCR_CKS_HI:TCR_CKS_LO]);
  assign w_unused_tcr = ^{tcr_reg[6], tcr_reg[3:2]};

  timer_prescaler u_psc (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_en      (w_en),
    .i_clr     (w_load_edge),
    .i_cks     (w_cks),
`ifdef TIMER_EXT_CLK_EN
    .i_ext_clk (ext_clk),
`endif
    .o_tick    (w_tick)
  );

  // Load has priority over a coincident tick and suppresses its flag.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tcnt   <= '0;
      r_load_q <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_load_q <= tcr_reg[TCR_LOAD];
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      if (w_load_edge) begin
        r_tcnt <= tdr_reg;
      end else if (w_tick) begin
        if (w_dir) begin
          r_tcnt <= r_tcnt - ONE;
          r_udf  <= (r_tcnt == '0);
        end else begin
          r_tcnt <= r_tcnt + ONE;
          r_ovf  <= &r_tcnt;
        end
      end
    end
  end

  assign tcnt  = r_tcnt;
  assign s_ovf = r_ovf;
  assign s_udf = r_udf;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized control
// traffic, compared cycle by cycle against an arithmetic reference model.
module tb_timer_counter;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] tdr;
  logic [7:0] tcr;
  logic       s_ovf;
  logic       s_udf;
  logic [7:0] tcnt;
`ifdef TIMER_EXT_CLK_EN
  logic       ext_clk = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: counter value, enabled-cycle count since last clear, last load bit.
  int m_tcnt, m_ecnt, m_prev, m_ovf, m_udf;
  int n_ovf, n_udf;

  timer_counter #(.DATA_WIDTH(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .tdr_reg (tdr),
    .tcr_reg (tcr),
`ifdef TIMER_EXT_CLK_EN
    .ext_clk (ext_clk),
`endif
    .s_ovf   (s_ovf),
    .s_udf   (s_udf),
    .tcnt    (tcnt)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_ecnt = 0; m_prev = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step();
    int  per;
    bit  ld, en, tick;
    if (!presetn) begin
      model_reset();
    end else begin
      ld   = tcr[7] && (m_prev == 0);
      en   = tcr[4];
      per  = 2 << int'(tcr[1:0]);
      tick = en && ((m_ecnt % per) == per - 1);
      m_ovf = 0;
      m_udf = 0;
      if (ld) begin
        m_tcnt = int'(tdr);
      end else if (tick) begin
        if (tcr[5]) begin
          m_udf  = (m_tcnt == 0);
          m_tcnt = (m_tcnt + 255) % 256;
        end else begin
          m_ovf  = (m_tcnt == 255);
          m_tcnt = (m_tcnt + 1) % 256;
        end
      end
      m_ecnt = (ld || !en) ? 0 : (m_ecnt + 1) % 16;
      m_prev = int'(tcr[7]);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge pclk);
      #1;
      chk("tcnt", 32'(tcnt), 32'(m_tcnt));
      chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("s_udf", 32'(s_udf), 32'(m_udf));
      chk("flags_exclusive", 32'(s_ovf & s_udf), 32'd0);
      n_ovf += int'(s_ovf);
      n_udf += int'(s_udf);
    end
  endtask

  task automatic async_reset();
    presetn = 1'b0;
    #1;
    model_reset();
    chk("rst_tcnt", 32'(tcnt), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_udf", 32'(s_udf), 32'd0);
  endtask

  initial begin
    presetn = 1'b0;
    tdr     = 8'h00;
    tcr     = 8'h00;
    model_reset();
    n_ovf = 0; n_udf = 0;

    // Reset state
    #2;
    chk("reset_tcnt", 32'(tcnt), 32'd0);
    cycle(3);
    presetn = 1'b1;
    cycle(2);

    // Up count through overflow from 0xFD, cks=00
    tdr = 8'hFD; tcr = 8'h80;
    cycle(1);
    chk("up_load", 32'(tcnt), 32'hFD);
    tcr = 8'h10; n_ovf = 0; n_udf = 0;
    cycle(2); chk("up_fe", 32'(tcnt), 32'hFE);
    cycle(2); chk("up_ff", 32'(tcnt), 32'hFF);
    cycle(2); chk("up_00", 32'(tcnt), 32'h00);
    chk("up_ovf_pulses", 32'(n_ovf), 32'd1);

    // Down count through underflow from 0x02, cks=01
    tcr = 8'h00; cycle(1);
    tdr = 8'h02; tcr = 8'h80; cycle(1);
    tcr = 8'h31; n_ovf = 0; n_udf = 0;
    cycle(4);  chk("dn_01", 32'(tcnt), 32'h01);
    cycle(4);  chk("dn_00", 32'(tcnt), 32'h00);
    cycle(4);  chk("dn_ff", 32'(tcnt), 32'hFF);
    chk("dn_udf_pulses", 32'(n_udf), 32'd1);
    chk("dn_ovf_pulses", 32'(n_ovf), 32'd0);

    // Load edge coinciding with a tick at 0xFF
    tcr = 8'h00; cycle(1);
    tdr = 8'hFF; tcr = 8'h80; cycle(1);
    tcr = 8'h10; cycle(1);
    tdr = 8'h33; tcr = 8'h90; n_ovf = 0;
    cycle(1);
    chk("ld_tick_tcnt", 32'(tcnt), 32'h33);
    chk("ld_tick_no_ovf", 32'(n_ovf), 32'd0);

    // Enable dropped at 0x40 for 10 cycles
    tcr = 8'h00; cycle(1);
    tdr = 8'h3F; tcr = 8'h80; cycle(1);
    tcr = 8'h10; cycle(2);
    chk("en_at_40", 32'(tcnt), 32'h40);
    tcr = 8'h00; cycle(10);
    chk("en_hold_40", 32'(tcnt), 32'h40);
    tcr = 8'h10; cycle(1);
    chk("reen_1cyc", 32'(tcnt), 32'h40);
    cycle(1);
    chk("reen_2cyc", 32'(tcnt), 32'h41);

    // Reset mid-count at 0x80 with load bit held high across it
    tcr = 8'h00; cycle(1);
    tdr = 8'h80; tcr = 8'h80; cycle(1);
    tcr = 8'h90; cycle(1);
    chk("pre_rst_80", 32'(tcnt), 32'h80);
    async_reset();
    tdr = 8'h5A;
    cycle(2);
    presetn = 1'b1;
    cycle(1);
    chk("post_rst_load", 32'(tcnt), 32'h5A);
    tdr = 8'h11;
    cycle(6);

    // Reset right as an overflow pulse is showing
    tcr = 8'h00; cycle(1);
    tdr = 8'hFF; tcr = 8'h80; cycle(1);
    tcr = 8'h10; cycle(2);
    chk("ovf_before_rst", 32'(s_ovf), 32'd1);
    async_reset();
    cycle(1);
    presetn = 1'b1;
    tcr = 8'h00;
    cycle(2);

`ifdef TIMER_EXT_CLK_EN
    // External clock source on cks=11: each edge advances by one, 2-3 pclk later
    tdr = 8'h20; tcr = 8'h80; cycle(1);
    tcr = 8'h13;
    for (int e = 0; e < 5; e++) begin
      ext_clk = 1'b1;
      @(posedge pclk); #1;
      chk("ext_early", 32'(tcnt), 32'(8'h20 + e));
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      chk("ext_step", 32'(tcnt), 32'(8'h21 + e));
      ext_clk = 1'b0;
      repeat (4) @(posedge pclk);
      #1;
    end
    chk("ext_total", 32'(tcnt), 32'h25);
    tcr = 8'h00;
    m_tcnt = 8'h25; m_ecnt = 0; m_prev = 0;
    cycle(2);
`endif

    // Randomized control traffic
    for (int blk = 0; blk < 120; blk++) begin
      logic [7:0] r;
      r   = 8'($urandom);
      tcr = {($urandom_range(0, 5) == 0), r[6:0]};
`ifdef TIMER_EXT_CLK_EN
      if (tcr[1:0] == 2'b11) tcr[1] = 1'b0;
`endif
      tdr = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tdr = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 40) == 0) begin
        async_reset();
        cycle(1);
        presetn = 1'b1;
      end
      cycle($urandom_range(1, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
